debounce_timer_scheduler: RTL and testbench
===========================================

# debounce_timer_scheduler

Shares one debounce timer among N noisy push-button inputs instead of instantiating one FSM and one 20 ms timer per input. A round-robin scheduler grants the timer to one input whose synchronized level disagrees with its debounced level. It commits the new level only if that input holds steady for the full timer period. The block sits between board button pins and user logic, replacing per-button debouncer instances where timer area matters.

## Interface
- `N`, default 4: number of inputs; N ≥ 2.
- `SATURATION_VALUE`, default 1_999_999: terminal count of the shared timer. The timer spans SATURATION_VALUE+1 clocks, which is 20 ms at 100 MHz.
- `CW`, default $clog2(SATURATION_VALUE+1): counter width, derived, not overridden.
- `IW`, default $clog2(N): owner index width, derived.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `noisy`, input, N: raw button levels, asynchronous to `clk`.
- `debounced`, output, N: committed clean levels.
- `press_pulse`, output, N: one-cycle pulse when `debounced[i]` goes 0→1.
- `release_pulse`, output, N: one-cycle pulse when `debounced[i]` goes 1→0.
- `busy`, output, 1: high while the timer is granted (TIMING or COMMIT).
- `owner`, output, IW: index currently granted; holds the last granted index when idle.

## Operation
- **Synchronizer:** two-flop synchronizer per bit, `noisy` → `sync`. Both stages reset to 0.
- **Mismatch:** `mismatch[i] = sync[i] ^ debounced[i]`.
- **Round-robin pointer:** `last` (IW bits) resets to N-1, so the first search starts at index 0. The search order is last+1, last+2, …, wrapping modulo N. The first set `mismatch` bit in that order wins.

State machine (reset state IDLE):
- **IDLE:** if any `mismatch` is set, latch `owner` = winner and `target` = `sync[winner]`, clear `count` to 0, and go to TIMING. Otherwise stay in IDLE.
- **TIMING:** each cycle, check `sync[owner]`.
  - If `sync[owner]` ≠ `target` (a bounce or return to the old level): abort, set `last` = `owner`, clear `count`, go to IDLE. `debounced` is unchanged.
  - Else if `count` == SATURATION_VALUE: go to COMMIT. On the same edge, `debounced[owner]` ← `target`, and `press_pulse[owner]` or `release_pulse[owner]` is set according to `target`.
  - Else `count` ← `count` + 1.
- **COMMIT:** exactly one cycle. All pulse bits clear on the exit edge. `last` ← `owner`. Go to IDLE.

Rules:
- `count` never exceeds SATURATION_VALUE and never wraps.
- Changes on non-owner inputs during TIMING are ignored until IDLE re-evaluates. Their `mismatch` simply persists.
- At most one pulse bit across both pulse vectors is high in any cycle.
- Fairness: because `last` advances after both aborts and commits, a continuously chattering input cannot starve the others. Every pending input is granted within N grants.
- **Reset mid-operation:** asserting `reset_n` low immediately clears everything, regardless of state:
  - state → IDLE
  - `count` → 0
  - `last` → N-1
  - `owner` → 0
  - `debounced`, both pulse vectors, `busy`, synchronizer flops → 0

## Timing
- Reset values of all outputs are 0.
- Latency is measured from edge E0, the first edge at which `sync` stage 1 samples a level that then stays stable, with the timer idle:
  - `sync` changes at E0+1.
  - Grant (TIMING, `count` = 0) at E0+2.
  - `debounced` and the pulse change at E0+SATURATION_VALUE+3.
  - Pulse clears and state returns to IDLE at E0+SATURATION_VALUE+4.
- An input that is waiting for a grant adds the remaining occupancy of the current owner, plus one IDLE cycle, to its latency.
- Back-to-back grants have a minimum spacing: COMMIT → IDLE → TIMING, so one IDLE cycle separates consecutive TIMING windows.
- `busy` is registered and is high exactly in the TIMING and COMMIT cycles.

## Test plan
All scenarios use N=4 and SATURATION_VALUE=9.
- **Clean press:** `noisy[0]` 0→1 and held → `debounced[0]` rises exactly 12 cycles after E0, `press_pulse[0]` is high for exactly 1 cycle, `busy` is high for 11 cycles, then a clean release gives a matching `release_pulse[0]`.
- **Bounce abort:** `noisy[1]` goes high for 5 cycles, low for 3, then high and held → the first window aborts with no pulse, and `debounced[1]` rises 12 cycles after the final E0.
- **Simultaneous:** `noisy[2]` and `noisy[0]` rise on the same edge after reset → `owner` = 0 is committed first, then `owner` = 2. `debounced[2]` rises 12 cycles after `debounced[0]`.
- **Fairness:** `noisy[0]` toggles every 4 cycles forever while `noisy[3]` rises and holds → `debounced[3]` rises within 2 grants, and `debounced[0]` never changes.
- **Reset mid-TIMING:** pull `reset_n` low at `count` = 6 → all outputs are 0 immediately. After release, with `noisy` still high, a fresh 12-cycle debounce completes.
- **Pulse exclusivity:** random stimulus on all 4 inputs for 10k cycles → at most one pulse bit is ever high, and every `debounced` edge has exactly one matching pulse.

Source files
------------

// File: rtl/debounce_timer_scheduler.sv
// rtl/debounce_timer_scheduler.sv - N-input button debouncer sharing one round-robin timer
//
// One timer is granted to one input at a time. The granted input's new level
// is committed only after it has held steady for SATURATION_VALUE+1 clocks.
//
// Ports:
//   clk           : rising-edge clock
//   reset_n       : asynchronous active-low reset
//   noisy[N]      : raw button levels, asynchronous to clk
//   debounced[N]  : committed clean levels
//   press_pulse   : one-cycle pulse on debounced[i] 0->1
//   release_pulse : one-cycle pulse on debounced[i] 1->0
//   busy          : timer granted (TIMING or COMMIT)
//   owner         : index currently or last granted
module debounce_timer_scheduler #(
  parameter int N                = 4,
  parameter int SATURATION_VALUE = 1_999_999,
  localparam int CW              = $clog2(SATURATION_VALUE + 1),
  localparam int IW              = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  noisy,
  output logic [N-1:0]  debounced,
  output logic [N-1:0]  press_pulse,
  output logic [N-1:0]  release_pulse,
  output logic          busy,
  output logic [IW-1:0] owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TIMING = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [CW-1:0] SAT_C  = CW'(SATURATION_VALUE);
  localparam logic [IW-1:0] LAST_0 = IW'(N - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  logic [N-1:0]  r_debounced;
  logic [N-1:0]  r_press;
  logic [N-1:0]  r_release;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_last;
  logic          r_target;
  logic          r_busy;

  logic [N-1:0]  w_mismatch;
  logic          w_found;
  logic [IW-1:0] w_winner;
  logic          w_hold;
  logic          w_sat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= noisy;
      r_sync2 <= r_sync1;
    end
  end

  assign w_mismatch = r_sync2 ^ r_debounced;
  assign w_hold     = (r_sync2[r_owner] == r_target);
  assign w_sat      = (r_count == SAT_C);

  // Search starts just after the last granted index so a chattering input
  // cannot keep winning ahead of the others.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && w_mismatch[(int'(r_last) + k) % N]) begin
        w_found  = 1'b1;
        w_winner = IW'((int'(r_last) + k) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next = S_TIMING;
        end
      end
      S_TIMING: begin
        if (!w_hold) begin
          w_state_next = S_IDLE;
        end else if (w_sat) begin
          w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_debounced <= '0;
      r_press     <= '0;
      r_release   <= '0;
      r_count     <= '0;
      r_owner     <= '0;
      r_last      <= LAST_0;
      r_target    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner  <= w_winner;
            r_target <= r_sync2[w_winner];
            r_count  <= '0;
          end
        end
        S_TIMING: begin
          if (!w_hold) begin
            // Bounce or return to the old level: give up the timer and
            // advance the pointer so others get a turn.
            r_last  <= r_owner;
            r_count <= '0;
          end else if (w_sat) begin
            r_debounced[r_owner] <= r_target;
            r_press[r_owner]     <= r_target;
            r_release[r_owner]   <= ~r_target;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_COMMIT: begin
          r_press   <= '0;
          r_release <= '0;
          r_last    <= r_owner;
        end
        default: begin
          r_press   <= '0;
          r_release <= '0;
        end
      endcase
    end
  end

  assign debounced     = r_debounced;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign busy          = r_busy;
  assign owner         = r_owner;

endmodule

// File: tb/tb_debounce_timer_scheduler.sv
// tb/tb_debounce_timer_scheduler.sv - scoreboard bench for debounce_timer_scheduler
module tb_debounce_timer_scheduler;

  localparam int NN  = 4;
  localparam int SAT = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NN-1:0] noisy = '0;
  logic [NN-1:0] debounced;
  logic [NN-1:0] press_pulse;
  logic [NN-1:0] release_pulse;
  logic          busy;
  logic [1:0]    owner;

  debounce_timer_scheduler #(.N(NN), .SATURATION_VALUE(SAT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .noisy         (noisy),
    .debounced     (debounced),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .busy          (busy),
    .owner         (owner)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int idx;
    bit dir;
    int at;
  } ev_t;
  ev_t exp_q[$];

  // Reference model: sync pipeline plus a "grant window" that must see the
  // target level for SAT+1 consecutive edges before the level is committed.
  bit [NN-1:0] m_s1, m_s2, m_db;
  bit          m_act, m_tgt, m_busy, m_commit;
  int          m_own, m_gnt, m_free, m_last, m_owner_out;

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      m_act = 0; m_busy = 0; m_last = NN - 1; m_owner_out = 0; m_free = 0;
      exp_q.delete();
    end else begin
      m_commit = 0;
      if (m_act) begin
        if (m_s2[m_own] != m_tgt) begin
          m_act = 0; m_last = m_own; m_free = cyc + 1;
        end else if (cyc == m_gnt + SAT + 1) begin
          m_db[m_own] = m_tgt;
          exp_q.push_back('{m_own, m_tgt, cyc});
          m_act = 0; m_last = m_own; m_free = cyc + 2; m_commit = 1;
        end
      end else if (cyc >= m_free) begin
        for (int k = 1; k <= NN; k++) begin
          int i;
          i = (m_last + k) % NN;
          if (!m_act && m_s2[i] != m_db[i]) begin
            m_act = 1; m_own = i; m_tgt = m_s2[i]; m_gnt = cyc; m_owner_out = i;
          end
        end
      end
      m_busy = m_act || m_commit;
      m_s2 = m_s1;
      m_s1 = noisy;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected pulses and checks state every cycle.
  logic [NN-1:0] prev_db = '0;
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      prev_db = '0;
    end else begin
      logic [NN-1:0] ep, er;
      ep = '0; er = '0;
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.at == cyc) begin
          if (e.dir) ep[e.idx] = 1'b1; else er[e.idx] = 1'b1;
        end else begin
          chk("missed_pulse", 0, 1);
        end
      end
      chk("press_pulse", press_pulse, ep);
      chk("release_pulse", release_pulse, er);
      chk("debounced", debounced, m_db);
      chk("busy", busy, m_busy);
      chk("owner", owner, m_owner_out);
      chk("pulse_onehot", ($countones({press_pulse, release_pulse}) <= 1), 1);
      chk("edge_has_pulse", {press_pulse, release_pulse},
          {debounced & ~prev_db, ~debounced & prev_db});
      prev_db = debounced;
    end
  end

  int fp[NN];
  int fr[NN];
  int bcnt;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Latencies are measured from E0, the edge after the call.
  task automatic watch(input int cycles, input bit tog0);
    int k0;
    k0 = cyc;
    bcnt = 0;
    for (int i = 0; i < NN; i++) begin
      fp[i] = -1;
      fr[i] = -1;
    end
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      #1;
      if (busy) bcnt++;
      for (int i = 0; i < NN; i++) begin
        if (press_pulse[i] && fp[i] < 0) fp[i] = cyc - k0 - 1;
        if (release_pulse[i] && fr[i] < 0) fr[i] = cyc - k0 - 1;
      end
      if (tog0 && (c % 4) == 3) noisy[0] = ~noisy[0];
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  initial begin
    step(1);
    chk("reset_outputs", {debounced, press_pulse, release_pulse, busy, owner}, 0);
    step(1);
    reset_n = 1'b1;
    step(3);

    // Clean press then clean release on input 0
    noisy[0] = 1'b1;
    watch(20, 0);
    chk("clean_press_lat", fp[0], 12);
    chk("clean_busy_cycles", bcnt, 11);
    noisy[0] = 1'b0;
    watch(20, 0);
    chk("clean_release_lat", fr[0], 12);

    // Bounce on input 1: first window must abort
    noisy[1] = 1'b1;
    step(5);
    noisy[1] = 1'b0;
    step(3);
    noisy[1] = 1'b1;
    watch(20, 0);
    chk("bounce_final_lat", fp[1], 12);
    noisy[1] = 1'b0;
    watch(20, 0);
    chk("bounce_release_lat", fr[1], 12);

    // Simultaneous rise of 0 and 2 after reset
    do_reset();
    noisy = 4'b0101;
    watch(40, 0);
    chk("simul_lat0", fp[0], 12);
    chk("simul_lat2", fp[2], 24);

    // Fairness: input 0 chatters while input 3 rises and holds
    noisy = '0;
    do_reset();
    noisy[0] = 1'b1;
    step(1);
    noisy[3] = 1'b1;
    watch(60, 1);
    chk("fair_lat3_bound", (fp[3] >= 12 && fp[3] <= 24), 1);
    chk("fair_no_press0", fp[0], -1);
    chk("fair_no_release0", fr[0], -1);

    // Reset in the middle of a TIMING window
    noisy = '0;
    do_reset();
    step(2);
    noisy[0] = 1'b1;
    step(9);
    chk("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {debounced, press_pulse, release_pulse, busy, owner}, 0);
    step(2);
    reset_n = 1'b1;
    watch(20, 0);
    chk("post_reset_lat", fp[0], 12);

    // Random chatter on all inputs
    noisy = '0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NN; i++) begin
        if ($urandom_range(0, 15) == 0) noisy[i] = ~noisy[i];
      end
      step(1);
    end
    step(80);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_debounced", debounced, noisy);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
